xadc_sample_avg: RTL and testbench

XADC_SAMPLE_AVG -- requirements
Module: xadc_sample_avg

---
 rtl/xadc_sample_avg.sv | 127 ++++++++++++
 tb/tb_xadc_sample_avg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_sample_avg.sv
// XADC DRP sampler: reads the status register on each EOC and block-averages 2^AVG_LOG2 codes.
// Optional XADC_OVERRUN_CNT_EN adds an 8-bit saturating count of EOCs that arrive while a read is busy.
module xadc_sample_avg #(
    parameter logic [6:0] DRP_ADDR = 7'h03,
    parameter int         AVG_LOG2 = 3,
    parameter int         TIMEOUT  = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        eoc,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic [15:0] xadc_data,
    output logic        data_valid,
    output logic        timeout_err
`ifdef XADC_OVERRUN_CNT_EN
    ,
    output logic [7:0]  overrun_count
`endif
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [11:0]      r_avg;
    logic [11:0]      w_avg;
    logic             r_valid;
    logic             r_timeout;
    logic             w_capture;
    logic             w_timeout;
    logic             w_last;
    logic             w_unused_nib;

    assign drp_daddr    = DRP_ADDR;
    assign drp_dwe      = 1'b0;
    assign drp_di       = 16'h0000;
    assign xadc_data    = {r_avg, 4'b0000};
    assign data_valid   = r_valid;
    assign timeout_err  = r_timeout;
    assign w_unused_nib = &{1'b0, drp_do[3:0]};

    // Drdy wins over a timeout landing on the same cycle.
    assign w_capture = (r_state == S_WAIT) && drp_drdy;
    assign w_timeout = (r_state == S_WAIT) && !drp_drdy && (r_wait_cnt == CNT_LAST);
    assign w_last    = (r_idx == IDX_LAST);
    assign w_sum     = r_acc + ACC_W'(drp_do[15:4]);
    assign w_avg     = w_sum[AVG_LOG2 +: 12];

    always_comb begin
        w_state_nxt = r_state;
        drp_den     = 1'b0;
        case (r_state)
            S_IDLE: if (eoc) w_state_nxt = S_REQ;
            S_REQ: begin
                drp_den     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: if (w_capture || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture stage: accumulate, and on the last sample of a block publish the average.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
            r_avg      <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (r_state != S_WAIT)
                r_wait_cnt <= '0;
            else if (!w_capture && !w_timeout)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (w_timeout)
                r_timeout <= 1'b1;
            if (w_capture) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_last) begin
                    r_avg   <= w_avg;
                    r_acc   <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

`ifdef XADC_OVERRUN_CNT_EN
    logic [7:0] r_overrun;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign overrun_count = r_overrun;

    always_ff @(posedge clock) begin
        if (!resetn)
            r_overrun <= 8'd0;
        else if (eoc && (r_state != S_IDLE))
            r_overrun <= sat_inc8(r_overrun);
    end
`endif

endmodule

// File: tb/tb_xadc_sample_avg.sv
// Directed/random bench for xadc_sample_avg with a block-average reference model.
// Define XADC_OVERRUN_CNT_EN for both files to also check the overrun counter.
module tb_xadc_sample_avg;

    localparam int N = 8;

    logic        clock = 1'b0;
    logic        resetn;
    logic        eoc;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic [15:0] xadc_data;
    logic        data_valid;
    logic        timeout_err;
`ifdef XADC_OVERRUN_CNT_EN
    logic [7:0]  overrun_count;
`endif

    xadc_sample_avg dut (
        .clock        (clock),
        .resetn       (resetn),
        .eoc          (eoc),
        .drp_den      (drp_den),
        .drp_daddr    (drp_daddr),
        .drp_dwe      (drp_dwe),
        .drp_di       (drp_di),
        .drp_drdy     (drp_drdy),
        .drp_do       (drp_do),
        .xadc_data    (xadc_data),
        .data_valid   (data_valid),
        .timeout_err  (timeout_err)
`ifdef XADC_OVERRUN_CNT_EN
        ,
        .overrun_count(overrun_count)
`endif
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int den_cnt  = 0;

    // reference model state
    int          m_sum;
    int          m_cnt;
    logic [15:0] m_data;
    int          m_ovr;

    always @(posedge clock) if (drp_den === 1'b1) den_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset;
        m_sum  = 0;
        m_cnt  = 0;
        m_data = 16'h0000;
        m_ovr  = 0;
    endtask

    task automatic do_reset;
        resetn   = 1'b0;
        eoc      = 1'b0;
        drp_drdy = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
        model_reset;
    endtask

    task automatic model_sample(input logic [15:0] d, output logic exp_v);
        m_sum += int'(d[15:4]);
        m_cnt++;
        exp_v = 1'b0;
        if (m_cnt == N) begin
            m_data = {12'(m_sum / N), 4'h0};
            m_sum  = 0;
            m_cnt  = 0;
            exp_v  = 1'b1;
        end
    endtask

    task automatic check_ovr;
`ifdef XADC_OVERRUN_CNT_EN
        chk("overrun_count", overrun_count, m_ovr);
`endif
    endtask

    // One full DRP read: eoc, den, optional busy-time eocs, drdy after lat cycles.
    task automatic read(input logic [15:0] d, input int lat, input int n_ovr, input bit simul);
        logic ev;
        int   den0;
        den0 = den_cnt;
        eoc  = 1'b1;
        tick;
        eoc = 1'b0;
        chk("den_req", drp_den, 1);
        tick;
        chk("den_wait", drp_den, 0);
        for (int i = 0; i < n_ovr; i++) begin
            eoc = 1'b1;
            m_ovr++;
            tick;
            eoc = 1'b0;
            tick;
        end
        for (int i = 0; i < lat; i++) tick;
        drp_do   = d;
        drp_drdy = 1'b1;
        eoc      = simul;
        if (simul) m_ovr++;
        tick;
        drp_drdy = 1'b0;
        eoc      = 1'b0;
        drp_do   = 16'($urandom);
        model_sample(d, ev);
        chk("valid", data_valid, ev);
        chk("xadc_data", xadc_data, m_data);
        chk("den_after", drp_den, 0);
        chk("den_count", den_cnt - den0, 1);
        tick;
        chk("valid_clr", data_valid, 0);
        chk("den_idle", drp_den, 0);
    endtask

    initial begin
        int n;
        resetn   = 1'b1;
        eoc      = 1'b0;
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        model_reset;

        do_reset;
        chk("rst_data", xadc_data, 16'h0000);
        chk("rst_valid", data_valid, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_den", drp_den, 0);
        chk("daddr", drp_daddr, 7'h03);
        chk("dwe", drp_dwe, 0);
        chk("di", drp_di, 16'h0000);
        check_ovr;

        // constant input
        for (int i = 0; i < N; i++) read(16'h8000, int'($urandom_range(0, 5)), 0, 1'b0);
        chk("const_data", xadc_data, 16'h8000);

        // ramp 0..7 -> 28>>3 = 3
        for (int i = 0; i < N; i++) read(16'(i << 4), int'($urandom_range(0, 3)), 0, 1'b0);
        chk("ramp_data", xadc_data, 16'h0030);

        // random blocks, low nibble must be ignored
        for (int i = 0; i < 2 * N; i++) read(16'($urandom), int'($urandom_range(0, 4)), 0, 1'b0);

        // timeout
        eoc = 1'b1;
        tick;
        eoc = 1'b0;
        chk("to_den", drp_den, 1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 400) begin
            tick;
            n++;
            if (n == 255) chk("to_early", timeout_err, 0);
        end
        chk("to_cycles", n, 256);
        chk("to_flag", timeout_err, 1);
        chk("to_data_held", xadc_data, m_data);
        drp_do   = 16'h1230;
        drp_drdy = 1'b1;
        tick;
        drp_drdy = 1'b0;
        chk("stray_drdy_valid", data_valid, 0);
        chk("stray_drdy_den", drp_den, 0);
        for (int i = 0; i < N; i++) read(16'hFFF0, int'($urandom_range(0, 5)), 0, 1'b0);
        chk("to_after_data", xadc_data, 16'hFFF0);
        chk("to_sticky", timeout_err, 1);

        // simultaneous eoc+drdy, and eocs while busy
        for (int i = 0; i < N; i++)
            read(16'($urandom), int'($urandom_range(0, 3)), (i == 5) ? 3 : 0, (i == 2));
        check_ovr;

        // reset mid-average and mid-read
        for (int i = 0; i < 5; i++) read(16'hFFF0, 1, 0, 1'b0);
        eoc = 1'b1;
        tick;
        eoc = 1'b0;
        tick;
        do_reset;
        chk("mid_rst_data", xadc_data, 16'h0000);
        chk("mid_rst_timeout", timeout_err, 0);
        chk("mid_rst_den", drp_den, 0);
        check_ovr;
        drp_do   = 16'hABC0;
        drp_drdy = 1'b1;
        tick;
        drp_drdy = 1'b0;
        chk("post_rst_stray", data_valid, 0);
        for (int i = 0; i < N; i++) read(16'h1000, int'($urandom_range(0, 5)), 0, 1'b0);
        chk("rst_avg_data", xadc_data, 16'h1000);
        chk("rst_avg_timeout", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
